// File: rtl/hilo_acc_file.sv
// hilo_acc_file
//   N_ACC independent {HI,LO} accumulator pairs. Pair 0 is the architectural HI/LO.
//   - Direct write port (WB): per-half mode, out-of-range pair ignored.
//   - Combinational read port with same-cycle bypass of the direct write.
//   - MAC engine IDLE -> MUL -> ACC: {HI,LO} +/- a*b, signed or unsigned.
// Ports
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_wen/i_wacc/i_wmode/i_hi/i_lo  direct write (mode 00 both, 01 HI, 10 LO, 11 none)
//   i_racc -> o_hi/o_lo             read port (out-of-range reads 0)
//   i_mac_*                         MAC launch, sampled only in IDLE
//   o_mac_busy                      high in MUL and ACC
//   o_stall_req                     busy, or a start being accepted this cycle
module hilo_acc_file #(
   parameter int N_REG = 32,
   parameter int N_ACC = 4,
   parameter int ACC_W = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wen,
   input  logic [ACC_W-1:0] i_wacc,
   input  logic [1:0]       i_wmode,
   input  logic [N_REG-1:0] i_hi,
   input  logic [N_REG-1:0] i_lo,
   input  logic [ACC_W-1:0] i_racc,
   output logic [N_REG-1:0] o_hi,
   output logic [N_REG-1:0] o_lo,
   input  logic             i_mac_start,
   input  logic             i_mac_sub,
   input  logic             i_mac_signed,
   input  logic [ACC_W-1:0] i_mac_acc,
   input  logic [N_REG-1:0] i_mac_a,
   input  logic [N_REG-1:0] i_mac_b,
   output logic             o_mac_busy,
   output logic             o_stall_req
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

   state_t               state_q, state_d;
   logic [N_REG-1:0]     hi_q [N_ACC];
   logic [N_REG-1:0]     lo_q [N_ACC];
   logic                 sub_q, sgn_q;
   logic [ACC_W-1:0]     macc_q;
   logic [N_REG-1:0]     a_q, b_q;
   logic [2*N_REG-1:0]   prod_q, prod_d;
   logic [2*N_REG-1:0]   a_ext, b_ext, cur, res_d;
   logic                 mac_we;

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_mac_start) state_d = S_MUL;
         S_MUL:   state_d = S_ACC;
         S_ACC:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign o_mac_busy  = (state_q == S_MUL) || (state_q == S_ACC);
   assign o_stall_req = o_mac_busy || (i_mac_start && (state_q == S_IDLE));

   // Extending both operands to 2*N_REG and keeping the low 2*N_REG bits of the
   // product gives the exact signed or unsigned result with one multiplier.
   always_comb begin
      a_ext  = sgn_q ? {{N_REG{a_q[N_REG-1]}}, a_q} : {{N_REG{1'b0}}, a_q};
      b_ext  = sgn_q ? {{N_REG{b_q[N_REG-1]}}, b_q} : {{N_REG{1'b0}}, b_q};
      prod_d = a_ext * b_ext;
   end

   // Accumulate against the currently stored pair (no bypass of a same-edge direct write).
   always_comb begin
      cur = '0;
      for (int i = 0; i < N_ACC; i++)
         if (macc_q == ACC_W'(i)) cur = {hi_q[i], lo_q[i]};
      res_d  = sub_q ? (cur - prod_q) : (cur + prod_q);
      mac_we = (state_q == S_ACC);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         prod_q  <= '0;
         sub_q   <= 1'b0;
         sgn_q   <= 1'b0;
         macc_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         for (int i = 0; i < N_ACC; i++) begin
            hi_q[i] <= '0;
            lo_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && i_mac_start) begin
            sub_q  <= i_mac_sub;
            sgn_q  <= i_mac_signed;
            macc_q <= i_mac_acc;
            a_q    <= i_mac_a;
            b_q    <= i_mac_b;
         end
         if (state_q == S_MUL) prod_q <= prod_d;
         // MAC writeback takes both halves over a colliding direct write.
         for (int i = 0; i < N_ACC; i++) begin
            if (mac_we && macc_q == ACC_W'(i)) begin
               hi_q[i] <= res_d[2*N_REG-1:N_REG];
               lo_q[i] <= res_d[N_REG-1:0];
            end else if (i_wen && i_wacc == ACC_W'(i)) begin
               if (!i_wmode[1]) hi_q[i] <= i_hi;
               if (!i_wmode[0]) lo_q[i] <= i_lo;
            end
         end
      end
   end

   // Read port: HI bypass for modes 00/01, LO bypass for modes 00/10.
   always_comb begin
      o_hi = '0;
      o_lo = '0;
      for (int i = 0; i < N_ACC; i++) begin
         if (i_racc == ACC_W'(i)) begin
            o_hi = (i_wen && i_wacc == i_racc && !i_wmode[1]) ? i_hi : hi_q[i];
            o_lo = (i_wen && i_wacc == i_racc && !i_wmode[0]) ? i_lo : lo_q[i];
         end
      end
   end

endmodule

// File: tb/tb_hilo_acc_file.sv
module tb_hilo_acc_file;

   logic        clk = 1'b0;
   logic        rst, wen, mac_start, mac_sub, mac_signed;
   logic [1:0]  wacc, wmode, racc, mac_acc;
   logic [31:0] hi, lo, o_hi, o_lo, mac_a, mac_b;
   logic        mac_busy, stall_req;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_hi [4];
   logic [31:0] m_lo [4];
   logic [63:0] sb_q [$];

   always #5 clk = ~clk;

   hilo_acc_file dut (
      .i_clk(clk), .i_rst(rst),
      .i_wen(wen), .i_wacc(wacc), .i_wmode(wmode), .i_hi(hi), .i_lo(lo),
      .i_racc(racc), .o_hi(o_hi), .o_lo(o_lo),
      .i_mac_start(mac_start), .i_mac_sub(mac_sub), .i_mac_signed(mac_signed),
      .i_mac_acc(mac_acc), .i_mac_a(mac_a), .i_mac_b(mac_b),
      .o_mac_busy(mac_busy), .o_stall_req(stall_req)
   );

   // All tasks start and end in the low phase of the clock, just after a negedge.
   task automatic wr(input logic [1:0] p, input logic [1:0] m, input logic [31:0] h, input logic [31:0] l);
      wen = 1'b1; wacc = p; wmode = m; hi = h; lo = l;
      @(negedge clk);
      wen = 1'b0;
      if (!m[1]) m_hi[p] = h;
      if (!m[0]) m_lo[p] = l;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin m_hi[i] = '0; m_lo[i] = '0; end
   endtask

   // Expected MAC result from the bench model, pushed to the scoreboard.
   task automatic push_mac(input logic [1:0] p, input logic sub, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
      logic [63:0] pr, cur;
      if (sgn) pr = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     pr = {32'b0, a} * {32'b0, b};
      cur = {m_hi[p], m_lo[p]};
      sb_q.push_back(sub ? cur - pr : cur + pr);
   endtask

   task automatic mac(input logic [1:0] p, input logic sub, input logic sgn,
                      input logic [31:0] a, input logic [31:0] b, input bit spurious);
      logic [63:0] exp;
      push_mac(p, sub, sgn, a, b);
      mac_start = 1'b1; mac_acc = p; mac_sub = sub; mac_signed = sgn; mac_a = a; mac_b = b;
      #1;
      checks++;
      if (stall_req !== 1'b1 || mac_busy !== 1'b0) begin
         failures++;
         $display("FAIL mac_launch stall=%b busy=%b required stall=1 busy=0", stall_req, mac_busy);
      end
      @(negedge clk);
      if (spurious) begin
         // A second start while busy must be dropped.
         mac_acc = 2'd2; mac_a = 32'hFFFF_FFFF; mac_b = 32'hFFFF_FFFF; mac_sub = 1'b0;
      end else mac_start = 1'b0;
      checks++;
      if (mac_busy !== 1'b1) begin failures++; $display("FAIL mac_busy_mul got=%b required=1", mac_busy); end
      @(negedge clk);
      mac_start = 1'b0;
      checks++;
      if (mac_busy !== 1'b1) begin failures++; $display("FAIL mac_busy_acc got=%b required=1", mac_busy); end
      @(negedge clk);
      checks++;
      if (mac_busy !== 1'b0) begin failures++; $display("FAIL mac_busy_idle got=%b required=0", mac_busy); end
      exp = sb_q.pop_front();
      racc = p; #1;
      checks++;
      if ({o_hi, o_lo} !== exp) begin
         failures++;
         $display("FAIL mac_result pair=%0d got=%h required=%h", p, {o_hi, o_lo}, exp);
      end
      m_hi[p] = exp[63:32]; m_lo[p] = exp[31:0];
   endtask

   task automatic test_reset();
      wr(2'd1, 2'b00, 32'd5, 32'd6);
      racc = 2'd1; #1;
      checks++;
      if ({o_hi, o_lo} !== {32'd5, 32'd6}) begin
         failures++; $display("FAIL reset_prewrite got=%h required=%h", {o_hi, o_lo}, {32'd5, 32'd6});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         racc = 2'(i); #1;
         checks++;
         if ({o_hi, o_lo} !== 64'd0) begin
            failures++; $display("FAIL reset_pair%0d got=%h required=0", i, {o_hi, o_lo});
         end
      end
      checks++;
      if (mac_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", mac_busy); end
   endtask

   task automatic test_modes();
      wr(2'd2, 2'b00, 32'hAAAA_0001, 32'hBBBB_0002);
      wr(2'd2, 2'b01, 32'hCCCC_0003, 32'h1111_1111);
      wr(2'd2, 2'b10, 32'h2222_2222, 32'hDDDD_0004);
      wr(2'd2, 2'b11, 32'hEEEE_0005, 32'hFFFF_0006);
      racc = 2'd2; #1;
      checks++;
      if ({o_hi, o_lo} !== {32'hCCCC_0003, 32'hDDDD_0004}) begin
         failures++;
         $display("FAIL modes got=%h required=%h", {o_hi, o_lo}, {32'hCCCC_0003, 32'hDDDD_0004});
      end
      // Neighbouring pairs are untouched.
      racc = 2'd3; #1;
      checks++;
      if ({o_hi, o_lo} !== {m_hi[3], m_lo[3]}) begin
         failures++; $display("FAIL modes_neighbour got=%h required=%h", {o_hi, o_lo}, {m_hi[3], m_lo[3]});
      end
   endtask

   task automatic test_bypass();
      wr(2'd0, 2'b00, 32'd1, 32'd2);
      wen = 1'b1; wacc = 2'd0; wmode = 2'b01; hi = 32'd9; lo = 32'd77; racc = 2'd0;
      #1;
      checks++;
      if (o_hi !== 32'd9 || o_lo !== 32'd2) begin
         failures++; $display("FAIL bypass_hi got=%h/%h required=9/2", o_hi, o_lo);
      end
      wmode = 2'b10; #1;
      checks++;
      if (o_hi !== 32'd1 || o_lo !== 32'd77) begin
         failures++; $display("FAIL bypass_lo got=%h/%h required=1/4d", o_hi, o_lo);
      end
      racc = 2'd2; #1;
      checks++;
      if ({o_hi, o_lo} !== {m_hi[2], m_lo[2]}) begin
         failures++; $display("FAIL bypass_other got=%h required=%h", {o_hi, o_lo}, {m_hi[2], m_lo[2]});
      end
      wen = 1'b0;
      wr(2'd0, 2'b00, 32'd0, 32'd10);
   endtask

   task automatic test_madd_signed();
      mac(2'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 1'b0);
      racc = 2'd0; #1;
      checks++;
      if ({o_hi, o_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
         failures++; $display("FAIL madd_signed_const got=%h required=fffffffffffffffe", {o_hi, o_lo});
      end
   endtask

   task automatic test_msub_wrap();
      wr(2'd3, 2'b00, 32'd0, 32'd0);
      mac(2'd3, 1'b1, 1'b0, 32'd2, 32'd2, 1'b1);
      racc = 2'd3; #1;
      checks++;
      if ({o_hi, o_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFC}) begin
         failures++; $display("FAIL msub_wrap_const got=%h required=fffffffffffffffc", {o_hi, o_lo});
      end
      repeat (3) @(negedge clk);
      racc = 2'd2; #1;
      checks++;
      if ({o_hi, o_lo} !== {m_hi[2], m_lo[2]} || mac_busy !== 1'b0) begin
         failures++;
         $display("FAIL spurious_start pair2=%h busy=%b required=%h busy=0", {o_hi, o_lo}, mac_busy, {m_hi[2], m_lo[2]});
      end
   endtask

   task automatic test_back_to_back();
      mac(2'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      mac(2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      mac(2'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
   endtask

   task automatic test_collision();
      logic [63:0] exp;
      for (int v = 0; v < 2; v++) begin
         wr(2'd1, 2'b00, 32'd0, 32'd100);
         push_mac(2'd1, 1'b0, 1'b0, 32'd3, 32'd3);
         mac_start = 1'b1; mac_acc = 2'd1; mac_sub = 1'b0; mac_signed = 1'b0; mac_a = 32'd3; mac_b = 32'd3;
         @(negedge clk);
         mac_start = 1'b0;
         @(negedge clk);
         // Direct write lands on the ACC edge: same pair (v=0) or another pair (v=1).
         wen = 1'b1; wacc = (v == 0) ? 2'd1 : 2'd2; wmode = 2'b00; hi = 32'hDEAD_0000; lo = 32'hBEEF_0000;
         @(negedge clk);
         wen = 1'b0;
         exp = sb_q.pop_front();
         m_hi[1] = exp[63:32]; m_lo[1] = exp[31:0];
         if (v == 1) begin m_hi[2] = 32'hDEAD_0000; m_lo[2] = 32'hBEEF_0000; end
         racc = 2'd1; #1;
         checks++;
         if ({o_hi, o_lo} !== exp) begin
            failures++; $display("FAIL collision_v%0d_mac got=%h required=%h", v, {o_hi, o_lo}, exp);
         end
         racc = 2'd2; #1;
         checks++;
         if ({o_hi, o_lo} !== {m_hi[2], m_lo[2]}) begin
            failures++; $display("FAIL collision_v%0d_pair2 got=%h required=%h", v, {o_hi, o_lo}, {m_hi[2], m_lo[2]});
         end
      end
   endtask

   task automatic test_abort();
      int cyc;
      mac_start = 1'b1; mac_acc = 2'd1; mac_sub = 1'b0; mac_signed = 1'b0; mac_a = 32'd50; mac_b = 32'd50;
      @(negedge clk);
      mac_start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      checks++;
      if (mac_busy !== 1'b0 || stall_req !== 1'b0) begin
         failures++; $display("FAIL abort_busy busy=%b stall=%b required 0/0", mac_busy, stall_req);
      end
      repeat (3) @(negedge clk);
      racc = 2'd1; #1;
      checks++;
      if ({o_hi, o_lo} !== 64'd0 || mac_busy !== 1'b0) begin
         failures++; $display("FAIL abort_writeback pair1=%h busy=%b required 0 busy=0", {o_hi, o_lo}, mac_busy);
      end
      // Engine is usable again after the abort; wait for idle with a bound.
      mac(2'd1, 1'b0, 1'b1, 32'd2, 32'hFFFF_FFFD, 1'b0);
      cyc = 0;
      while (mac_busy && cyc < 10) begin @(negedge clk); cyc++; end
      checks++;
      if (mac_busy !== 1'b0) begin failures++; $display("FAIL abort_idle_timeout busy=%b required=0", mac_busy); end
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; wacc = '0; wmode = '0; hi = '0; lo = '0; racc = '0;
      mac_start = 1'b0; mac_sub = 1'b0; mac_signed = 1'b0; mac_acc = '0; mac_a = '0; mac_b = '0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_modes();
      test_bypass();
      test_madd_signed();
      test_msub_wrap();
      test_back_to_back();
      test_collision();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
